// File: rtl/trace_ser_pkg.sv
// Shared types and defaults for the trace serializer (state encoding, default widths).
package trace_ser_pkg;

   localparam int unsigned DEF_DATA_W = 60;
   localparam int unsigned DEF_SYM_W  = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Number of symbols carried by one decision word.
   function automatic int unsigned sym_count(input int unsigned data_w, input int unsigned sym_w);
      return data_w / sym_w;
   endfunction

endpackage

// File: rtl/trace_ser_hold.sv
// One-word holding register used to accept the next decision word while the current one shifts out.
module trace_ser_hold
   import trace_ser_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_rd,
   output logic              o_full,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [DATA_W-1:0] r_data;

   // Clear beats write; write and read never overlap because write needs empty and read needs full.
   always_ff @(posedge clk) begin
      if (!rst || i_clr) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_wr) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_rd) begin
         r_full <= 1'b0;
         r_data <= '0;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

// File: rtl/trace_serializer.sv
// Serializes a traceback decision word into SYM_W-bit symbols, MSB first, with valid/ready handshake.
// Define TRACE_SERIALIZER_DBUF_EN to add a holding register for back-to-back words.
module trace_serializer
   import trace_ser_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned SYM_W  = DEF_SYM_W,
   localparam int unsigned NSYM  = sym_count(DATA_W, SYM_W),
   localparam int unsigned IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [SYM_W-1:0]  o_sym,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_last
);

   if (((DATA_W % SYM_W) != 0) || (NSYM < 2)) begin : g_param_check
      $error("trace_serializer: DATA_W must be a multiple of SYM_W giving at least two symbols");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
   logic [SYM_W-1:0]  r_sym;
   logic [IDX_W-1:0]  r_idx;
   logic              r_last;
   logic              r_valid;

   logic              w_accept;
   logic              w_xfer;
   logic              w_xfer_last;
   logic              w_start;
   logic [DATA_W-1:0] w_start_data;

   assign w_accept    = i_load && o_ready && !i_flush;
   assign w_xfer      = r_valid && i_ready;
   assign w_xfer_last = w_xfer && r_last;

`ifdef TRACE_SERIALIZER_DBUF_EN
   logic              w_hold_full;
   logic [DATA_W-1:0] w_hold_data;
   logic              w_hold_wr;
   logic              w_hold_rd;

   assign o_ready = !w_hold_full;

   // A word arriving while idle, or exactly as the last symbol leaves, goes straight to the shifter.
   assign w_hold_wr    = w_accept && (r_state == SHIFT) && !w_xfer_last;
   assign w_hold_rd    = w_xfer_last && w_hold_full && !i_flush;
   assign w_start      = (w_accept && !w_hold_wr) || w_hold_rd;
   assign w_start_data = w_hold_rd ? w_hold_data : i_data;

   trace_ser_hold #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (i_flush),
      .i_wr   (w_hold_wr),
      .i_data (i_data),
      .i_rd   (w_hold_rd),
      .o_full (w_hold_full),
      .o_data (w_hold_data)
   );
`else
   assign o_ready      = (r_state == IDLE);
   assign w_start      = w_accept;
   assign w_start_data = i_data;
`endif

   // State, shifter and registered symbol outputs; flush shares the reset path and wins over everything.
   always_ff @(posedge clk) begin
      if (!rst || i_flush) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_sym   <= '0;
         r_idx   <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_start) begin
         r_state <= SHIFT;
         r_shift <= w_start_data << SYM_W;
         r_sym   <= w_start_data[DATA_W-1 -: SYM_W];
         r_idx   <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b1;
      end else if (w_xfer_last) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_sym   <= '0;
         r_idx   <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_xfer) begin
         r_shift <= r_shift << SYM_W;
         r_sym   <= r_shift[DATA_W-1 -: SYM_W];
         r_idx   <= r_idx + IDX_W'(1);
         r_last  <= (r_idx == (LAST_IDX - IDX_W'(1)));
      end
   end

   assign o_valid = r_valid;
   assign o_sym   = r_sym;
   assign o_idx   = r_idx;
   assign o_last  = r_last;

endmodule

// File: tb/tb_trace_serializer.sv
// Scoreboard bench for trace_serializer: default 60/4 instance plus a 120/2 parameter sweep instance.
module tb_trace_serializer;

   localparam int unsigned DW = 60;
   localparam int unsigned SW = 4;
   localparam int unsigned NS = 15;
   localparam int unsigned IW = 4;

   logic          clk;
   logic          rst;
   logic          i_load;
   logic [DW-1:0] i_data;
   logic          o_ready;
   logic          i_flush;
   logic          o_valid;
   logic          i_ready;
   logic [SW-1:0] o_sym;
   logic [IW-1:0] o_idx;
   logic          o_last;

   logic          i_load2;
   logic [119:0]  i_data2;
   logic          o_ready2;
   logic          i_flush2;
   logic          o_valid2;
   logic          i_ready2;
   logic [1:0]    o_sym2;
   logic [5:0]    o_idx2;
   logic          o_last2;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [SW-1:0] sym;
      logic [IW-1:0] idx;
      logic          last;
   } exp_t;

   exp_t q[$];

   trace_serializer #(.DATA_W(DW), .SYM_W(SW)) dut (
      .clk(clk), .rst(rst), .i_load(i_load), .i_data(i_data), .o_ready(o_ready),
      .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_sym(o_sym),
      .o_idx(o_idx), .o_last(o_last)
   );

   trace_serializer #(.DATA_W(120), .SYM_W(2)) dut2 (
      .clk(clk), .rst(rst), .i_load(i_load2), .i_data(i_data2), .o_ready(o_ready2),
      .i_flush(i_flush2), .o_valid(o_valid2), .i_ready(i_ready2), .o_sym(o_sym2),
      .o_idx(o_idx2), .o_last(o_last2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: pop one expected symbol per transfer; idle outputs must read zero.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1 && i_flush === 1'b0) begin
         n_checks++;
         if (q.size() == 0) begin
            $display("FAIL sb_underflow: got sym=%h idx=%0d with no expected symbol queued", o_sym, o_idx);
         end else begin
            e = q.pop_front();
            if ({o_sym, o_idx, o_last} !== {e.sym, e.idx, e.last})
               $display("FAIL sb_sym: got sym=%h idx=%0d last=%b, want sym=%h idx=%0d last=%b",
                        o_sym, o_idx, o_last, e.sym, e.idx, e.last);
            else
               n_pass++;
         end
      end
      if (o_valid === 1'b0) begin
         n_checks++;
         if ({o_sym, o_idx, o_last} !== '0)
            $display("FAIL idle_zero: got sym=%h idx=%0d last=%b, want all zero", o_sym, o_idx, o_last);
         else
            n_pass++;
      end
   end

   task automatic push_word(input logic [DW-1:0] w);
      for (int i = 0; i < int'(NS); i++)
         q.push_back('{sym: w[DW-1-SW*i -: SW], idx: IW'(i), last: (i == int'(NS) - 1)});
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((q.size() != 0 || o_valid !== 1'b0) && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_checks++;
      if (q.size() != 0 || o_valid !== 1'b0)
         $display("FAIL %s_drain: pending=%0d o_valid=%b, want pending=0 o_valid=0", name, q.size(), o_valid);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({o_valid, o_sym, o_idx, o_last} !== '0)
         $display("FAIL reset_outputs: got valid=%b sym=%h idx=%0d last=%b, want all zero", o_valid, o_sym, o_idx, o_last);
      else n_pass++;
      n_checks++;
      if (o_valid2 !== 1'b0)
         $display("FAIL reset_valid2: got %b, want 0", o_valid2);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1 || o_ready2 !== 1'b1)
         $display("FAIL reset_ready: got %b/%b, want 1/1", o_ready, o_ready2);
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [DW-1:0] w = 60'h123456789ABCDEF;
      @(posedge clk); #1;
      n_checks++;
      if (o_ready !== 1'b1) $display("FAIL basic_ready_pre: got %b, want 1", o_ready);
      else n_pass++;
      i_load = 1'b1; i_data = w; push_word(w);
      @(posedge clk); #1;
      i_load = 1'b0;
      for (int k = 0; k < int'(NS); k++) begin
         n_checks++;
         if (o_valid !== 1'b1 || o_idx !== IW'(k) || o_sym !== SW'(k + 1) || o_last !== (k == int'(NS) - 1))
            $display("FAIL basic_cycle%0d: got valid=%b idx=%0d sym=%h last=%b, want 1 %0d %h %b",
                     k, o_valid, o_idx, o_sym, o_last, k, k + 1, (k == int'(NS) - 1));
         else n_pass++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
         $display("FAIL basic_after: got valid=%b ready=%b, want 0 1", o_valid, o_ready);
      else n_pass++;
      wait_drain("basic");
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] w = 60'h123456789ABCDEF;
      @(posedge clk); #1;
      i_load = 1'b1; i_data = w; push_word(w);
      @(posedge clk); #1;
      i_load = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      i_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 3) i_ready = 1'b1;
         n_checks++;
         if (o_valid !== 1'b1 || o_idx !== IW'(5) || o_sym !== 4'h6 || o_last !== 1'b0)
            $display("FAIL bp_hold%0d: got valid=%b idx=%0d sym=%h, want 1 5 6", c, o_valid, o_idx, o_sym);
         else n_pass++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_idx !== IW'(6) || o_sym !== 4'h7)
         $display("FAIL bp_resume: got idx=%0d sym=%h, want 6 7", o_idx, o_sym);
      else n_pass++;
      wait_drain("bp");
   endtask

   task automatic test_flush();
      logic [DW-1:0] w = 60'h0FEDCBA98765432;
      @(posedge clk); #1;
      i_load = 1'b1; i_data = w; push_word(w);
      @(posedge clk); #1;
      i_load = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      n_checks++;
      if (o_idx !== IW'(7)) $display("FAIL flush_pos: got idx=%0d, want 7", o_idx);
      else n_pass++;
      i_flush = 1'b1; i_load = 1'b1; i_data = 60'hAAAAAAAAAAAAAAA;
      q.delete();
      @(posedge clk); #1;
      i_flush = 1'b0; i_load = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
         $display("FAIL flush_after: got valid=%b ready=%b, want 0 1", o_valid, o_ready);
      else n_pass++;
      repeat (2) begin @(posedge clk); #1; end
      n_checks++;
      if (o_valid !== 1'b0) $display("FAIL flush_load_ignored: got valid=%b, want 0", o_valid);
      else n_pass++;
      wait_drain("flush");
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w  = 60'h123456789ABCDEF;
      logic [DW-1:0] w2 = 60'hFEDCBA987654321;
      @(posedge clk); #1;
      i_load = 1'b1; i_data = w; push_word(w);
      @(posedge clk); #1;
      i_load = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      q.delete();
      @(posedge clk); #1;
      n_checks++;
      if ({o_valid, o_sym, o_idx, o_last} !== '0)
         $display("FAIL rstmid_outputs: got valid=%b sym=%h idx=%0d last=%b, want all zero", o_valid, o_sym, o_idx, o_last);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) $display("FAIL rstmid_ready: got %b, want 1", o_ready);
      else n_pass++;
      @(posedge clk); #1;
      i_load = 1'b1; i_data = w2; push_word(w2);
      @(posedge clk); #1;
      i_load = 1'b0;
      n_checks++;
      if (o_valid !== 1'b1 || o_idx !== '0 || o_sym !== 4'hF)
         $display("FAIL rstmid_restart: got valid=%b idx=%0d sym=%h, want 1 0 f", o_valid, o_idx, o_sym);
      else n_pass++;
      wait_drain("rstmid");
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] wa = 60'h111111111111111;
      logic [DW-1:0] wb = 60'h222222222222222;
      bit b_acc = 1'b0;
      bit exp_v;
      bit exp_l;
      @(posedge clk); #1;
      i_load = 1'b1; i_data = wa; push_word(wa);
      @(posedge clk); #1;
      i_data = wb;
      for (int c = 1; c <= 35; c++) begin
`ifdef TRACE_SERIALIZER_DBUF_EN
         exp_v = (c <= 30);
         exp_l = (c == 15) || (c == 30);
`else
         exp_v = (c <= 15) || (c >= 17 && c <= 31);
         exp_l = (c == 15) || (c == 31);
`endif
         n_checks++;
         if (o_valid !== exp_v || o_last !== exp_l)
            $display("FAIL b2b_cycle%0d: got valid=%b last=%b, want %b %b", c, o_valid, o_last, exp_v, exp_l);
         else n_pass++;
         if (!b_acc && o_ready === 1'b1) begin
            b_acc = 1'b1;
            push_word(wb);
         end
         @(posedge clk); #1;
         if (b_acc) i_load = 1'b0;
      end
      i_load = 1'b0;
      wait_drain("b2b");
   endtask

   task automatic test_sweep();
      logic [119:0] w;
      int lasts = 0;
      for (int k = 0; k < 60; k++) w[119-2*k -: 2] = 2'(k);
      @(posedge clk); #1;
      i_load2 = 1'b1; i_data2 = w;
      @(posedge clk); #1;
      i_load2 = 1'b0;
      for (int k = 0; k < 60; k++) begin
         n_checks++;
         if (o_valid2 !== 1'b1 || o_idx2 !== 6'(k) || o_sym2 !== 2'(k) || o_last2 !== (k == 59))
            $display("FAIL sweep_cycle%0d: got valid=%b idx=%0d sym=%0d last=%b, want 1 %0d %0d %b",
                     k, o_valid2, o_idx2, o_sym2, o_last2, k, k % 4, (k == 59));
         else n_pass++;
         if (o_last2 === 1'b1) lasts++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_valid2 !== 1'b0 || o_ready2 !== 1'b1 || lasts != 1)
         $display("FAIL sweep_end: got valid=%b ready=%b lasts=%0d, want 0 1 1", o_valid2, o_ready2, lasts);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; i_load = 1'b0; i_data = '0; i_flush = 1'b0; i_ready = 1'b1;
      i_load2 = 1'b0; i_data2 = '0; i_flush2 = 1'b0; i_ready2 = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
